alu_seq_ctrl: RTL and testbench

Sequenced successor to the combinational ALU controller. The current ALU has shift primitives for 1, 2 and 8 bits only. This block breaks any shift amount into a chain of those primitives, one per cycle, and holds the multiply code for a configurable number of cycles. All other operations are single-step. It sits between the decode/ID stage and the EX-stage ALU and drives the ALU control code, the operand-feedback select and the sequence-end flag.

---
 rtl/alu_seq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl
// Description : Sequenced ALU controller. Splits shifts into by8/by2/by1
//               primitive steps and holds the multiply code for MUL_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl #(
    parameter int                CTRL_W     = 6,
    parameter int                SHAMT_W    = 5,
    parameter int                MUL_CYCLES = 4,
    parameter logic [CTRL_W-1:0] NOP_CODE   = 'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inValid,
    output logic               inReady,
    input  logic [4:0]         ALUop,
    input  logic [5:0]         functionCode,
    input  logic [SHAMT_W-1:0] Shamt,
    input  logic               hold,
    output logic               stepValid,
    output logic [CTRL_W-1:0]  ALUctrl,
    output logic               useFeedback,
    output logic               last
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        MUL    = 2'd2,
        SINGLE = 2'd3
    } state_t;

    localparam int MUL_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES + 1) : 1;

    state_t              state;
    logic [SHAMT_W-1:0]  cnt8;
    logic [1:0]          cnt2;
    logic                cnt1;
    logic [CTRL_W-1:0]   sh_base;
    logic [MUL_W-1:0]    mul_left;

    logic                accept;
    state_t              dec_state;
    logic [CTRL_W-1:0]   dec_code;
    logic [CTRL_W-1:0]   dec_base;

    logic [SHAMT_W-1:0]  n8, nx8;
    logic [1:0]          n2, nx2;
    logic                n1, nx1;
    logic [CTRL_W-1:0]   base;
    logic [CTRL_W-1:0]   sh_code;
    logic                sh_last;

    assign inReady = !hold && (state == IDLE || last);
    assign accept  = inValid && inReady;

    // Operation decode; shifts carry the by8 primitive code as their base.
    always_comb begin
        dec_state = SINGLE;
        dec_code  = NOP_CODE;
        dec_base  = CTRL_W'('hC);
        case (ALUop)
            5'd0: dec_code = CTRL_W'('h2);
            5'd1: dec_code = CTRL_W'('h6);
            5'd3: dec_code = CTRL_W'('h3);
            5'd4: dec_code = CTRL_W'('h0);
            5'd5: dec_code = CTRL_W'('h1);
            5'd6: dec_code = CTRL_W'('h4);
            5'd7: dec_code = CTRL_W'('h7);
            5'd8: dec_code = CTRL_W'('h8);
            5'd9: dec_code = CTRL_W'('h9);
            5'd2: begin
                case (functionCode)
                    6'h00: begin
                        dec_base  = CTRL_W'('hC);
                        dec_state = (Shamt == '0) ? SINGLE : SHIFT;
                    end
                    6'h02: begin
                        dec_base  = CTRL_W'('hF);
                        dec_state = (Shamt == '0) ? SINGLE : SHIFT;
                    end
                    6'h03: begin
                        dec_base  = CTRL_W'('h12);
                        dec_state = (Shamt == '0) ? SINGLE : SHIFT;
                    end
                    6'h19: begin
                        dec_state = MUL;
                        dec_code  = CTRL_W'('h13);
                    end
                    6'h20: dec_code = CTRL_W'('h2);
                    6'h21: dec_code = CTRL_W'('h3);
                    6'h23: dec_code = CTRL_W'('h6);
                    6'h24: dec_code = CTRL_W'('h0);
                    6'h25: dec_code = CTRL_W'('h1);
                    6'h26: dec_code = CTRL_W'('h4);
                    6'h2A: dec_code = CTRL_W'('h7);
                    6'h2B: dec_code = CTRL_W'('h8);
                    6'h30: dec_code = CTRL_W'('h14);
                    default: dec_code = NOP_CODE;
                endcase
            end
            default: dec_code = NOP_CODE;
        endcase
    end

    // Next shift step: counters hold the steps still owed after the current one.
    always_comb begin
        n8   = accept ? (Shamt >> 3) : cnt8;
        n2   = accept ? Shamt[2:1]   : cnt2;
        n1   = accept ? Shamt[0]     : cnt1;
        base = accept ? dec_base     : sh_base;
        nx8  = n8;
        nx2  = n2;
        nx1  = n1;
        if (n8 != '0) begin
            sh_code = base;
            nx8     = n8 - SHAMT_W'(1);
        end else if (n2 != 2'd0) begin
            sh_code = base - CTRL_W'(1);
            nx2     = n2 - 2'd1;
        end else begin
            sh_code = base - CTRL_W'(2);
            nx1     = 1'b0;
        end
        sh_last = (nx8 == '0) && (nx2 == 2'd0) && !nx1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            stepValid   <= 1'b0;
            ALUctrl     <= NOP_CODE;
            useFeedback <= 1'b0;
            last        <= 1'b0;
            cnt8        <= '0;
            cnt2        <= 2'd0;
            cnt1        <= 1'b0;
            sh_base     <= CTRL_W'('hC);
            mul_left    <= '0;
        end else if (!hold) begin
            if (accept) begin
                state       <= dec_state;
                stepValid   <= 1'b1;
                useFeedback <= 1'b0;
                case (dec_state)
                    SHIFT: begin
                        ALUctrl <= sh_code;
                        last    <= sh_last;
                        cnt8    <= nx8;
                        cnt2    <= nx2;
                        cnt1    <= nx1;
                        sh_base <= dec_base;
                    end
                    MUL: begin
                        ALUctrl  <= dec_code;
                        last     <= (MUL_CYCLES == 1);
                        mul_left <= MUL_W'(MUL_CYCLES - 1);
                    end
                    default: begin
                        ALUctrl <= dec_code;
                        last    <= 1'b1;
                    end
                endcase
            end else if (state == IDLE || last) begin
                state       <= IDLE;
                stepValid   <= 1'b0;
                ALUctrl     <= NOP_CODE;
                useFeedback <= 1'b0;
                last        <= 1'b0;
            end else if (state == SHIFT) begin
                ALUctrl     <= sh_code;
                useFeedback <= 1'b1;
                last        <= sh_last;
                cnt8        <= nx8;
                cnt2        <= nx2;
                cnt1        <= nx1;
            end else begin
                mul_left <= mul_left - MUL_W'(1);
                last     <= (mul_left == MUL_W'(1));
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_ctrl
// Description : Self-checking bench for alu_seq_ctrl (decode table, directed
//               multi-cycle sequences, randomized run against a step-list model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

    localparam int MULC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       inValid;
    logic       hold;
    logic [4:0] ALUop;
    logic [5:0] functionCode;
    logic [4:0] Shamt;

    logic       inReady, stepValid, useFeedback, last;
    logic [5:0] ALUctrl;
    logic       inReady1, stepValid1, useFeedback1, last1;
    logic [5:0] ALUctrl1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int code;
        bit fb;
        bit last;
    } step_t;

    typedef struct {
        logic [4:0] op;
        logic [5:0] fn;
        logic [4:0] sh;
        int         code;
    } vec_t;

    step_t q[$];

    alu_seq_ctrl #(.CTRL_W(6), .SHAMT_W(5), .MUL_CYCLES(MULC), .NOP_CODE(6'h0)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
        .ALUop(ALUop), .functionCode(functionCode), .Shamt(Shamt), .hold(hold),
        .stepValid(stepValid), .ALUctrl(ALUctrl), .useFeedback(useFeedback), .last(last)
    );

    alu_seq_ctrl #(.CTRL_W(6), .SHAMT_W(5), .MUL_CYCLES(1), .NOP_CODE(6'h0)) dut1 (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady1),
        .ALUop(ALUop), .functionCode(functionCode), .Shamt(Shamt), .hold(hold),
        .stepValid(stepValid1), .ALUctrl(ALUctrl1), .useFeedback(useFeedback1), .last(last1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int single_code(input int op, input int fn);
        case (op)
            0: return 'h2;
            1: return 'h6;
            3: return 'h3;
            4: return 'h0;
            5: return 'h1;
            6: return 'h4;
            7: return 'h7;
            8: return 'h8;
            9: return 'h9;
            2: begin
                case (fn)
                    'h20: return 'h2;
                    'h21: return 'h3;
                    'h23: return 'h6;
                    'h24: return 'h0;
                    'h25: return 'h1;
                    'h26: return 'h4;
                    'h2A: return 'h7;
                    'h2B: return 'h8;
                    'h30: return 'h14;
                    default: return 'h0;
                endcase
            end
            default: return 'h0;
        endcase
    endfunction

    // Expected step list of one operation, built from the decomposition rule.
    task automatic build(input int op, input int fn, input int s, input int mulc);
        int b;
        q.delete();
        if (op == 2 && (fn == 0 || fn == 2 || fn == 3)) begin
            b = (fn == 0) ? 'hC : (fn == 2) ? 'hF : 'h12;
            if (s == 0) q.push_back('{0, 1'b0, 1'b1});
            else begin
                for (int i = 0; i < s / 8; i++)       q.push_back('{b, 1'b1, 1'b0});
                for (int i = 0; i < (s % 8) / 2; i++) q.push_back('{b - 1, 1'b1, 1'b0});
                for (int i = 0; i < s % 2; i++)       q.push_back('{b - 2, 1'b1, 1'b0});
                q[0].fb = 1'b0;
                q[q.size()-1].last = 1'b1;
            end
        end else if (op == 2 && fn == 'h19) begin
            for (int i = 0; i < mulc; i++) q.push_back('{'h13, 1'b0, 1'b0});
            q[q.size()-1].last = 1'b1;
        end else begin
            q.push_back('{single_code(op, fn), 1'b0, 1'b1});
        end
    endtask

    task automatic offer(input int op, input int fn, input int s);
        inValid      = 1'b1;
        ALUop        = 5'(op);
        functionCode = 6'(fn);
        Shamt        = 5'(s);
    endtask

    task automatic chk_step(input string nm, input step_t e);
        chk({nm, ".valid"}, int'(stepValid), 1);
        chk({nm, ".code"},  int'(ALUctrl), e.code);
        chk({nm, ".fb"},    int'(useFeedback), int'(e.fb));
        chk({nm, ".last"},  int'(last), int'(e.last));
        chk({nm, ".ready"}, int'(inReady), int'(e.last));
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, ".valid"}, int'(stepValid), 0);
        chk({nm, ".last"},  int'(last), 0);
        chk({nm, ".ready"}, int'(inReady), 1);
    endtask

    // Offer an op now (at a negedge, DUT ready) and check every expected step.
    task automatic run_op(input string nm, input int op, input int fn, input int s);
        step_t e;
        build(op, fn, s, MULC);
        offer(op, fn, s);
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            inValid = 1'b0;
            chk_step(nm, e);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vec_t  vt[$];
        int    srl_c[4];
        step_t cur;
        bit    cur_v, rst_prev, acc, exp_rdy;
        int    fns[15];

        reset = 1'b1; inValid = 1'b0; hold = 1'b0;
        ALUop = '0; functionCode = '0; Shamt = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset.valid", int'(stepValid), 0);
        chk("reset.code",  int'(ALUctrl), 0);
        chk("reset.fb",    int'(useFeedback), 0);
        chk("reset.last",  int'(last), 0);
        chk("reset.ready", int'(inReady), 1);

        // Single-step decode table, expected codes written out by hand.
        vt = '{
            '{5'd0, 6'h00, 5'd0, 'h2},  '{5'd1, 6'h00, 5'd0, 'h6},  '{5'd3, 6'h00, 5'd0, 'h3},
            '{5'd4, 6'h3F, 5'd0, 'h0},  '{5'd5, 6'h00, 5'd0, 'h1},  '{5'd6, 6'h00, 5'd0, 'h4},
            '{5'd7, 6'h00, 5'd0, 'h7},  '{5'd8, 6'h00, 5'd0, 'h8},  '{5'd9, 6'h00, 5'd0, 'h9},
            '{5'd10, 6'h20, 5'd0, 'h0}, '{5'd31, 6'h20, 5'd0, 'h0},
            '{5'd2, 6'h20, 5'd0, 'h2},  '{5'd2, 6'h21, 5'd0, 'h3},  '{5'd2, 6'h23, 5'd0, 'h6},
            '{5'd2, 6'h24, 5'd0, 'h0},  '{5'd2, 6'h25, 5'd0, 'h1},  '{5'd2, 6'h26, 5'd0, 'h4},
            '{5'd2, 6'h2A, 5'd0, 'h7},  '{5'd2, 6'h2B, 5'd0, 'h8},  '{5'd2, 6'h30, 5'd0, 'h14},
            '{5'd2, 6'h10, 5'd0, 'h0},  '{5'd2, 6'h12, 5'd0, 'h0},  '{5'd2, 6'h3F, 5'd0, 'h0},
            '{5'd2, 6'h00, 5'd0, 'h0},  '{5'd2, 6'h02, 5'd1, 'hD},  '{5'd2, 6'h03, 5'd2, 'h11},
            '{5'd2, 6'h00, 5'd8, 'hC}
        };
        for (int i = 0; i < vt.size(); i++) begin
            offer(int'(vt[i].op), int'(vt[i].fn), int'(vt[i].sh));
            @(negedge clk);
            inValid = 1'b0;
            chk_step($sformatf("tbl%0d", i), '{vt[i].code, 1'b0, 1'b1});
            @(negedge clk);
            chk_idle($sformatf("tbl%0d.after", i));
        end

        // SRL s=13 with hand-written expectations.
        srl_c = '{'hF, 'hE, 'hE, 'hD};
        offer(2, 'h02, 13);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            inValid = 1'b0;
            chk_step($sformatf("srl13.s%0d", i), '{srl_c[i], i != 0, i == 3});
        end
        @(negedge clk);
        chk_idle("srl13.end");

        run_op("sll31", 2, 'h00, 31);
        @(negedge clk);
        chk_idle("sll31.end");

        // Reset while a long shift is in flight.
        offer(2, 'h00, 31);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            inValid = 1'b0;
            chk($sformatf("rstmid.s%0d", i), int'(ALUctrl), 'hC);
        end
        do_reset();
        chk("rstmid.valid", int'(stepValid), 0);
        chk("rstmid.code",  int'(ALUctrl), 0);
        chk("rstmid.ready", int'(inReady), 1);
        run_op("rstmid.add", 0, 0, 0);
        @(negedge clk);

        // Multiply on both instances: MUL_CYCLES=4 and MUL_CYCLES=1.
        do_reset();
        offer(2, 'h19, 0);
        @(negedge clk);
        inValid = 1'b0;
        chk_step("mul4.s0", '{'h13, 1'b0, 1'b0});
        chk("mul1.valid", int'(stepValid1), 1);
        chk("mul1.code",  int'(ALUctrl1), 'h13);
        chk("mul1.fb",    int'(useFeedback1), 0);
        chk("mul1.last",  int'(last1), 1);
        for (int i = 1; i < MULC; i++) begin
            @(negedge clk);
            chk_step($sformatf("mul4.s%0d", i), '{'h13, 1'b0, i == MULC - 1});
            chk($sformatf("mul1.idle%0d", i), int'(stepValid1), 0);
        end
        @(negedge clk);
        chk_idle("mul4.end");

        // SRA s=9, then back-to-back ALUop=5 and funct 2B.
        offer(2, 'h03, 9);
        @(negedge clk);
        inValid = 1'b0;
        chk_step("sra9.s0", '{'h12, 1'b0, 1'b0});
        @(negedge clk);
        chk_step("sra9.s1", '{'h10, 1'b1, 1'b1});
        offer(5, 0, 0);
        @(negedge clk);
        chk_step("b2b.or", '{'h1, 1'b0, 1'b1});
        offer(2, 'h2B, 0);
        @(negedge clk);
        inValid = 1'b0;
        chk_step("b2b.sltu", '{'h8, 1'b0, 1'b1});
        @(negedge clk);
        chk_idle("b2b.end");

        // SLL s=10 with hold on the second step.
        offer(2, 'h00, 10);
        @(negedge clk);
        inValid = 1'b0;
        chk_step("hold.s0", '{'hC, 1'b0, 1'b0});
        @(negedge clk);
        chk_step("hold.s1", '{'hB, 1'b1, 1'b1});
        hold = 1'b1;
        #1;
        chk("hold.ready", int'(inReady), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("hold.h%0d.valid", i), int'(stepValid), 1);
            chk($sformatf("hold.h%0d.code", i),  int'(ALUctrl), 'hB);
            chk($sformatf("hold.h%0d.last", i),  int'(last), 1);
            chk($sformatf("hold.h%0d.ready", i), int'(inReady), 0);
        end
        hold = 1'b0;
        #1;
        chk("hold.release.ready", int'(inReady), 1);
        @(negedge clk);
        chk_idle("hold.end");

        // Randomized run against the step-list model.
        fns = '{'h00, 'h02, 'h03, 'h19, 'h20, 'h21, 'h23, 'h24, 'h25, 'h26,
                'h2A, 'h2B, 'h30, 'h10, 'h12};
        do_reset();
        cur_v = 1'b0; rst_prev = 1'b1;
        q.delete();
        for (int c = 0; c < 1500; c++) begin
            chk("rnd.valid", int'(stepValid), int'(cur_v));
            if (cur_v) begin
                chk("rnd.code", int'(ALUctrl), cur.code);
                chk("rnd.fb",   int'(useFeedback), int'(cur.fb));
                chk("rnd.last", int'(last), int'(cur.last));
            end else begin
                chk("rnd.idle_last", int'(last), 0);
            end
            if (rst_prev) chk("rnd.rst_code", int'(ALUctrl), 0);

            reset   = ($urandom_range(0, 99) == 0);
            hold    = ($urandom_range(0, 4) == 0);
            inValid = $urandom_range(0, 1) == 1;
            ALUop   = ($urandom_range(0, 1) == 1) ? 5'd2 : 5'($urandom_range(0, 31));
            functionCode = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63))
                                                       : 6'(fns[$urandom_range(0, 14)]);
            Shamt   = 5'($urandom_range(0, 31));
            #1;
            exp_rdy = !hold && (!cur_v || cur.last);
            chk("rnd.ready", int'(inReady), int'(exp_rdy));
            acc = inValid && exp_rdy;

            rst_prev = reset;
            if (reset) begin
                cur_v = 1'b0;
                q.delete();
            end else if (!hold) begin
                if (acc) begin
                    build(int'(ALUop), int'(functionCode), int'(Shamt), MULC);
                    cur   = q.pop_front();
                    cur_v = 1'b1;
                end else if (q.size() > 0) begin
                    cur = q.pop_front();
                end else begin
                    cur_v = 1'b0;
                end
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
